ps2_keycode_rx: RTL and testbench

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

---
 rtl/ps2_keycode_rx_pkg.sv | 26 ++
 rtl/ps2_keycode_rx_if.sv | 19 +
 rtl/ps2_keycode_rx_scan2usage.sv | 24 ++
 rtl/ps2_keycode_rx.sv | 176 +++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_keycode_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard front end of the tank controller.
package tank_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;

  localparam logic [15:0] KEY_W     = 16'h001A;
  localparam logic [15:0] KEY_A     = 16'h0004;
  localparam logic [15:0] KEY_S     = 16'h0016;
  localparam logic [15:0] KEY_D     = 16'h0007;
  localparam logic [15:0] KEY_SPACE = 16'h002C;
  localparam logic [15:0] KEY_ENTER = 16'h0028;

  // PS/2 frames use odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// PS/2 line pair plus decoded key outputs, bundled for benches and integrators.
interface ps2_keycode_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] keycode;
  logic        key_event;
  logic        frame_err;

  // Device side drives the PS/2 lines and observes the decoded result.
  modport master (
    output ps2_clk, ps2_data,
    input  keycode, key_event, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, key_event, frame_err
  );
endinterface

// File: rtl/ps2_keycode_rx_scan2usage.sv
// Combinational scan-code set 2 to USB HID usage lookup for the supported keys.
module ps2_scan2usage
  import tank_kbd_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] usage,
  output logic       hit
);

  always_comb begin
    usage = '0;
    hit   = 1'b1;
    case (code)
      8'h1D:   usage = KEY_W[7:0];
      8'h1C:   usage = KEY_A[7:0];
      8'h1B:   usage = KEY_S[7:0];
      8'h23:   usage = KEY_D[7:0];
      8'h29:   usage = KEY_SPACE[7:0];
      8'h5A:   usage = KEY_ENTER[7:0];
      default: hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frames bytes off the device lines and tracks the held mapped key.
module ps2_keycode_rx
  import tank_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        key_event,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   break_pend_q, break_pend_d;
  logic                   ext_pend_q, ext_pend_d;
  logic [15:0]            keycode_q, keycode_d;
  logic                   key_event_q, key_event_d;
  logic                   frame_err_q, frame_err_d;

  logic       clk_cur, data_cur, fall, timeout, accept, err, mapped;
  logic [7:0] usage;
  logic       hit;

  ps2_scan2usage u_map (
    .code  (shift_q),
    .usage (usage),
    .hit   (hit)
  );

  assign clk_cur  = clk_sync_q[SYNC_STAGES-1];
  assign data_cur = data_sync_q[SYNC_STAGES-1];
  assign fall     = clk_prev_q & ~clk_cur;
  assign mapped   = hit & ~ext_pend_q;

  always_comb begin
    clk_sync_d  = clk_sync_q;
    data_sync_d = data_sync_q;
    clk_sync_d[0]  = ps2_clk;
    data_sync_d[0] = ps2_data;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      clk_sync_d[i]  = clk_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_prev_d   = clk_cur;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_d        = tmo_q;
    break_pend_d = break_pend_q;
    ext_pend_d   = ext_pend_q;
    keycode_d    = keycode_q;
    frame_err_d  = 1'b0;
    accept       = 1'b0;
    err          = 1'b0;

    // An edge always clears the counter, so it beats a coincident timeout.
    if (state_q == IDLE || fall) tmo_d = '0;
    else                         tmo_d = tmo_q + TW'(1);
    timeout = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    case (state_q)
      IDLE: begin
        if (fall && !data_cur) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_cur, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_cur;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (data_cur && odd_parity_ok(shift_q, parity_q)) accept = 1'b1;
          else                                               err    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      tmo_d     = '0;
      err       = 1'b1;
    end

    if (err) begin
      frame_err_d  = 1'b1;
      break_pend_d = 1'b0;
      ext_pend_d   = 1'b0;
    end

    if (accept) begin
      if (shift_q == BYTE_BREAK) begin
        break_pend_d = 1'b1;
      end else if (shift_q == BYTE_EXT) begin
        ext_pend_d = 1'b1;
      end else begin
        if (mapped) begin
          if (!break_pend_q)                       keycode_d = {8'h00, usage};
          else if (keycode_q == {8'h00, usage})    keycode_d = '0;
        end
        break_pend_d = 1'b0;
        ext_pend_d   = 1'b0;
      end
    end

    key_event_d = (keycode_d != keycode_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      break_pend_q <= 1'b0;
      ext_pend_q   <= 1'b0;
      keycode_q    <= '0;
      key_event_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      break_pend_q <= break_pend_d;
      ext_pend_q   <= ext_pend_d;
      keycode_q    <= keycode_d;
      key_event_q  <= key_event_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign keycode   = keycode_q;
  assign key_event = key_event_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: make/break tracking, frame errors, timeout and reset.
module tb_ps2_keycode_rx;
  import tank_kbd_pkg::*;

  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 20;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;
  int unsigned ev_cnt;
  int unsigned err_cnt;
  int unsigned ev_base;
  int unsigned err_base;

  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .keycode   (bus.keycode),
    .key_event (bus.key_event),
    .frame_err (bus.frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.key_event) ev_cnt++;
    if (bus.frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip_par,
                                           input logic stop);
    return {stop, (~^b) ^ flip_par, b, 1'b0};
  endfunction

  task automatic put_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
  endtask

  task automatic rise();
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      put_bit(f[i]);
      rise();
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0, 1'b1), 11);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [10:0] f;
    checks = 0; errors = 0; ev_cnt = 0; err_cnt = 0;
    bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_keycode", bus.keycode, 16'h0000);
    chk("rst_key_event", 16'(bus.key_event), 16'h0000);
    chk("rst_frame_err", 16'(bus.frame_err), 16'h0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Make 1D with exact update latency around the stop edge.
    ev_base = ev_cnt;
    f = mk_frame(8'h1D, 1'b0, 1'b1);
    send_bits(f, 10);
    put_bit(f[10]);
    repeat (2) @(negedge clk);
    chk("lat_before", bus.keycode, 16'h0000);
    @(negedge clk);
    chk("lat_keycode", bus.keycode, KEY_W);
    chk("lat_event_hi", 16'(bus.key_event), 16'h0001);
    @(negedge clk);
    chk("lat_event_lo", 16'(bus.key_event), 16'h0000);
    rise();
    repeat (5) @(negedge clk);

    send_byte(8'h1D);
    chk("typematic_kc", bus.keycode, KEY_W);
    chk("typematic_ev", 16'(ev_cnt - ev_base), 16'd1);
    send_byte(8'hF0);
    chk("f0_kc", bus.keycode, KEY_W);
    chk("f0_ev", 16'(ev_cnt - ev_base), 16'd1);
    send_byte(8'h1D);
    chk("brk_w_kc", bus.keycode, 16'h0000);
    chk("mkbrk_ev", 16'(ev_cnt - ev_base), 16'd2);

    // Last pressed wins; releasing the older key keeps the newer one.
    ev_base = ev_cnt;
    send_byte(8'h1D);
    chk("mk_w", bus.keycode, KEY_W);
    send_byte(8'h1C);
    chk("mk_a", bus.keycode, KEY_A);
    send_byte(8'hF0);
    send_byte(8'h1D);
    chk("brk_other", bus.keycode, KEY_A);
    chk("two_key_ev", 16'(ev_cnt - ev_base), 16'd2);
    send_byte(8'hE0);
    send_byte(8'h1D);
    chk("ext_unmapped", bus.keycode, KEY_A);
    send_byte(8'h15);
    chk("unmapped_mk", bus.keycode, KEY_A);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("brk_a", bus.keycode, 16'h0000);

    // Parity and stop-bit errors.
    ev_base = ev_cnt; err_base = err_cnt;
    send_bits(mk_frame(8'h1D, 1'b1, 1'b1), 11);
    repeat (5) @(negedge clk);
    chk("par_err", 16'(err_cnt - err_base), 16'd1);
    chk("par_kc", bus.keycode, 16'h0000);
    chk("par_ev", 16'(ev_cnt - ev_base), 16'd0);
    send_bits(mk_frame(8'h1D, 1'b0, 1'b0), 11);
    repeat (5) @(negedge clk);
    chk("stop_err", 16'(err_cnt - err_base), 16'd2);
    chk("stop_kc", bus.keycode, 16'h0000);
    send_byte(8'hF0);
    send_bits(mk_frame(8'h1D, 1'b1, 1'b1), 11);
    repeat (5) @(negedge clk);
    send_byte(8'h1D);
    chk("err_clr_pend", bus.keycode, KEY_W);
    send_byte(8'hF0);
    send_byte(8'h1D);
    chk("cleanup", bus.keycode, 16'h0000);

    // Partial frame abandoned, then a good frame.
    err_base = err_cnt;
    send_bits(mk_frame(8'h1D, 1'b0, 1'b1), 5);
    repeat (TMO + 10) @(negedge clk);
    chk("tmo_err", 16'(err_cnt - err_base), 16'd1);
    chk("tmo_idle", 16'(dut.state_q), 16'(IDLE));
    send_byte(8'h23);
    chk("after_tmo", bus.keycode, KEY_D);

    // Reset in the middle of a frame.
    send_byte(8'h1D);
    chk("pre_rst", bus.keycode, KEY_W);
    err_base = err_cnt;
    send_bits(mk_frame(8'h1B, 1'b0, 1'b1), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_kc", bus.keycode, 16'h0000);
    repeat (5) @(negedge clk);
    send_byte(8'h1B);
    chk("after_rst", bus.keycode, KEY_S);
    chk("rst_no_err", 16'(err_cnt - err_base), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
